// File: rtl/stdp_synapse.sv
// stdp_synapse
// ------------
// Plastic synapse placed directly upstream of a LIF neuron. It turns
// presynaptic spikes into a weighted current pulse for the neuron. It takes
// the neuron's output spike as the postsynaptic event. It adapts its weight
// with pair-based STDP driven by exponentially decaying pre/post traces.
//
// Ports:
//   clk          clock
//   rst          synchronous reset, active-high
//   pre_spike    presynaptic spike, one-cycle pulse
//   post_spike   postsynaptic spike (LIF spike output)
//   learn_en     1 = weight updates enabled (traces evolve regardless)
//   current      synaptic current, registered: weight on a pre spike, else 0
//   weight       weight register
//   pre_trace    presynaptic trace register
//   post_trace   postsynaptic trace register
//   update_valid one-cycle pulse in the cycle after a learning event
//
// Optional feature (macro STDP_WEIGHT_LOAD_EN):
//   wload_valid  1 = load weight from wload_data on the next edge
//   wload_data   weight value to load (clamped to [W_MIN, W_MAX])
//
// This block has no handshakes. Spikes and loads are single-cycle strobes
// that are sampled on every rising edge and are never back-pressured.

module stdp_synapse #(
  parameter logic [7:0] WEIGHT_INIT  = 8'd64,
  parameter logic [7:0] W_MIN        = 8'd0,
  parameter logic [7:0] W_MAX        = 8'd255,
  parameter logic [7:0] TRACE_PEAK   = 8'd255,
  parameter int         DECAY_PERIOD = 16,
  parameter int         DECAY_SHIFT  = 3,
  parameter int         LTP_SHIFT    = 4,
  parameter int         LTD_SHIFT    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pre_spike,
  input  logic       post_spike,
  input  logic       learn_en,
`ifdef STDP_WEIGHT_LOAD_EN
  input  logic       wload_valid,
  input  logic [7:0] wload_data,
`endif
  output logic [7:0] current,
  output logic [7:0] weight,
  output logic [7:0] pre_trace,
  output logic [7:0] post_trace,
  output logic       update_valid
);

  localparam int CW = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;

  logic [CW-1:0]     pscale;
  logic              tick;
  logic [7:0]        pre_trace_next;
  logic [7:0]        post_trace_next;
  logic [7:0]        d_plus;
  logic [7:0]        d_minus;
  logic signed [9:0] w_sum;
  logic [7:0]        w_learn;
  logic [7:0]        weight_next;

  // One decay step. The decrement never drops below 1, so a small trace
  // still reaches 0 and does not stall at a value where trace >> shift == 0.
  function automatic logic [7:0] decay_step(input logic [7:0] t);
    logic [7:0] dec;
    dec = t >> DECAY_SHIFT;
    if (dec == 8'd0) dec = 8'd1;
    if (t == 8'd0) return 8'd0;
    return t - dec;
  endfunction

  assign tick = (pscale == CW'(DECAY_PERIOD - 1));

  always_comb begin
    pre_trace_next = pre_trace;
    if (pre_spike)  pre_trace_next = TRACE_PEAK;
    else if (tick)  pre_trace_next = decay_step(pre_trace);

    post_trace_next = post_trace;
    if (post_spike) post_trace_next = TRACE_PEAK;
    else if (tick)  post_trace_next = decay_step(post_trace);
  end

  // Learning reads the registered (old) traces. A spike in this cycle
  // therefore pairs only with earlier activity and never with itself.
  always_comb begin
    d_plus  = post_spike ? (pre_trace >> LTP_SHIFT) : 8'd0;
    d_minus = pre_spike  ? (post_trace >> LTD_SHIFT) : 8'd0;
    w_sum   = $signed({2'b00, weight}) + $signed({2'b00, d_plus})
            - $signed({2'b00, d_minus});
    if (w_sum < $signed({2'b00, W_MIN}))      w_learn = W_MIN;
    else if (w_sum > $signed({2'b00, W_MAX})) w_learn = W_MAX;
    else                                      w_learn = w_sum[7:0];
  end

  always_comb begin
    weight_next = weight;
    if (learn_en) weight_next = w_learn;
`ifdef STDP_WEIGHT_LOAD_EN
    // An explicit load wins over any learning delta in the same cycle.
    if (wload_valid) begin
      if (wload_data < W_MIN)      weight_next = W_MIN;
      else if (wload_data > W_MAX) weight_next = W_MAX;
      else                         weight_next = wload_data;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pscale       <= '0;
      pre_trace    <= 8'd0;
      post_trace   <= 8'd0;
      weight       <= WEIGHT_INIT;
      current      <= 8'd0;
      update_valid <= 1'b0;
    end else begin
      pscale       <= tick ? '0 : pscale + CW'(1);
      pre_trace    <= pre_trace_next;
      post_trace   <= post_trace_next;
      weight       <= weight_next;
      // The current reports the weight from before this cycle's LTD.
      current      <= pre_spike ? weight : 8'd0;
      update_valid <= learn_en & (pre_spike | post_spike);
    end
  end

endmodule

// File: tb/tb_stdp_synapse.sv
// tb_stdp_synapse
// ---------------
// Bench for stdp_synapse. Three instances share one stimulus stream:
// the default weight (64), a high weight (250) for upper saturation and a
// low weight (5) for lower saturation. A vector table covers the
// per-cycle scenarios. Hand-written sequences cover trace decay and the
// optional weight load.

module tb_stdp_synapse;

  logic       clk = 1'b0;
  logic       rst, pre_spike, post_spike, learn_en;
`ifdef STDP_WEIGHT_LOAD_EN
  logic       wload_valid;
  logic [7:0] wload_data;
`endif
  logic [7:0] current, weight, pre_trace, post_trace;
  logic       update_valid;
  logic [7:0] current_hi, weight_hi, pre_trace_hi, post_trace_hi;
  logic       update_valid_hi;
  logic [7:0] current_lo, weight_lo, pre_trace_lo, post_trace_lo;
  logic       update_valid_lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stdp_synapse dut (
    .clk(clk), .rst(rst), .pre_spike(pre_spike), .post_spike(post_spike),
    .learn_en(learn_en),
`ifdef STDP_WEIGHT_LOAD_EN
    .wload_valid(wload_valid), .wload_data(wload_data),
`endif
    .current(current), .weight(weight), .pre_trace(pre_trace),
    .post_trace(post_trace), .update_valid(update_valid)
  );

  stdp_synapse #(.WEIGHT_INIT(8'd250)) dut_hi (
    .clk(clk), .rst(rst), .pre_spike(pre_spike), .post_spike(post_spike),
    .learn_en(learn_en),
`ifdef STDP_WEIGHT_LOAD_EN
    .wload_valid(wload_valid), .wload_data(wload_data),
`endif
    .current(current_hi), .weight(weight_hi), .pre_trace(pre_trace_hi),
    .post_trace(post_trace_hi), .update_valid(update_valid_hi)
  );

  stdp_synapse #(.WEIGHT_INIT(8'd5)) dut_lo (
    .clk(clk), .rst(rst), .pre_spike(pre_spike), .post_spike(post_spike),
    .learn_en(learn_en),
`ifdef STDP_WEIGHT_LOAD_EN
    .wload_valid(wload_valid), .wload_data(wload_data),
`endif
    .current(current_lo), .weight(weight_lo), .pre_trace(pre_trace_lo),
    .post_trace(post_trace_lo), .update_valid(update_valid_lo)
  );

  typedef struct packed {
    logic       rst;
    logic       pre;
    logic       post;
    logic       learn;
    logic [7:0] ew;
    logic [7:0] ept;
    logic [7:0] eqt;
    logic [7:0] ecur;
    logic       euv;
    logic [7:0] ewh;
    logic [7:0] ewl;
  } vec_t;

  vec_t vec_q[$];

  task automatic add(input logic r, input logic p, input logic q, input logic l,
                     input logic [7:0] ew, input logic [7:0] ept,
                     input logic [7:0] eqt, input logic [7:0] ecur,
                     input logic euv, input logic [7:0] ewh,
                     input logic [7:0] ewl);
    vec_t v;
    v.rst = r; v.pre = p; v.post = q; v.learn = l;
    v.ew = ew; v.ept = ept; v.eqt = eqt; v.ecur = ecur; v.euv = euv;
    v.ewh = ewh; v.ewl = ewl;
    vec_q.push_back(v);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  // Apply one cycle of inputs away from the active edge, then sample
  // the outputs 1 ns after the rising edge.
  task automatic cycle(input logic r, input logic p, input logic q,
                       input logic l);
    @(negedge clk);
    rst = r; pre_spike = p; post_spike = q; learn_en = l;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] model_decay(input logic [7:0] t);
    logic [7:0] d;
    d = t >> 3;
    if (d == 8'd0) d = 8'd1;
    return (t == 8'd0) ? 8'd0 : t - d;
  endfunction

  logic [7:0] t_exp;

  initial begin
    rst = 1'b1; pre_spike = 1'b0; post_spike = 1'b0; learn_en = 1'b0;
`ifdef STDP_WEIGHT_LOAD_EN
    wload_valid = 1'b0; wload_data = 8'd0;
`endif

    //  rst pre post learn | w  ptr  qtr cur uv | w_hi w_lo
    // reset, including pre_spike held high during reset
    add(1, 1, 0, 1,  64,   0,   0,  0, 0,  250,  5);
    add(1, 1, 0, 1,  64,   0,   0,  0, 0,  250,  5);
    add(1, 0, 0, 1,  64,   0,   0,  0, 0,  250,  5);
    // pre then post: LTP of 255>>4 = 15
    add(0, 1, 0, 1,  64, 255,   0, 64, 1,  250,  5);
    add(0, 0, 1, 1,  79, 255, 255,  0, 1,  255, 20);
    add(0, 0, 0, 1,  79, 255, 255,  0, 0,  255, 20);
    // reset mid-operation with both spikes pending
    add(1, 1, 1, 1,  64,   0,   0,  0, 0,  250,  5);
    // post then pre: LTD of 15, current carries the pre-LTD weight
    add(0, 0, 1, 1,  64,   0, 255,  0, 1,  250,  5);
    add(0, 1, 0, 1,  49, 255, 255, 64, 1,  235,  0);
    add(0, 0, 0, 1,  49, 255, 255,  0, 0,  235,  0);
    // simultaneous pre+post: zero traces, then equal deltas cancel
    add(1, 0, 0, 1,  64,   0,   0,  0, 0,  250,  5);
    add(0, 1, 1, 1,  64, 255, 255, 64, 1,  250,  5);
    add(0, 1, 1, 1,  64, 255, 255, 64, 1,  250,  5);
    // learning disabled: weight holds, traces still move, no update pulse
    add(1, 0, 0, 0,  64,   0,   0,  0, 0,  250,  5);
    add(0, 1, 0, 0,  64, 255,   0, 64, 0,  250,  5);
    add(0, 0, 1, 0,  64, 255, 255,  0, 0,  250,  5);
    add(0, 0, 0, 0,  64, 255, 255,  0, 0,  250,  5);
    // back-to-back pre spikes: one current pulse each
    add(1, 0, 0, 1,  64,   0,   0,  0, 0,  250,  5);
    add(0, 1, 0, 1,  64, 255,   0, 64, 1,  250,  5);
    add(0, 1, 0, 1,  64, 255,   0, 64, 1,  250,  5);
    add(0, 0, 0, 1,  64, 255,   0,  0, 0,  250,  5);

    for (int i = 0; i < vec_q.size(); i++) begin
      cycle(vec_q[i].rst, vec_q[i].pre, vec_q[i].post, vec_q[i].learn);
      check("weight",       i, weight,              vec_q[i].ew);
      check("pre_trace",    i, pre_trace,           vec_q[i].ept);
      check("post_trace",   i, post_trace,          vec_q[i].eqt);
      check("current",      i, current,             vec_q[i].ecur);
      check("update_valid", i, {7'd0, update_valid}, {7'd0, vec_q[i].euv});
      check("weight_hi",    i, weight_hi,           vec_q[i].ewh);
      check("weight_lo",    i, weight_lo,           vec_q[i].ewl);
    end

    // Trace decay: one pre spike right after reset, then idle. Edge k
    // (k=1 is the spike edge) applies a decay tick when k % 16 == 0.
    cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 1);
    cycle(0, 1, 0, 1);
    check("decay_peak", 1, pre_trace, 8'd255);
    t_exp = 8'd255;
    for (int k = 2; k <= 720; k++) begin
      cycle(0, 0, 0, 1);
      if (k % 16 == 0) t_exp = model_decay(t_exp);
      if (k == 15) check("decay_pre_tick", k, pre_trace, 8'd255);
      if (k == 16) check("decay_tick1",    k, pre_trace, 8'd224);
      if (k == 31) check("decay_hold",     k, pre_trace, 8'd224);
      if (k == 32) check("decay_tick2",    k, pre_trace, 8'd196);
      if (k % 16 == 0) check("decay_model", k, pre_trace, t_exp);
    end
    check("decay_zero",      720, pre_trace,  8'd0);
    check("decay_post_idle", 720, post_trace, 8'd0);
    check("decay_weight",    720, weight,     8'd64);
    cycle(0, 0, 0, 1);
    check("decay_stay_zero", 721, pre_trace, 8'd0);

`ifdef STDP_WEIGHT_LOAD_EN
    // Weight load overrides a same-cycle LTP delta.
    cycle(1, 0, 0, 1);
    cycle(0, 1, 0, 1);
    @(negedge clk);
    rst = 1'b0; pre_spike = 1'b0; post_spike = 1'b1; learn_en = 1'b1;
    wload_valid = 1'b1; wload_data = 8'd200;
    @(posedge clk);
    #1;
    check("load_weight",    0, weight,    8'd200);
    check("load_weight_hi", 0, weight_hi, 8'd200);
    check("load_weight_lo", 0, weight_lo, 8'd200);
    check("load_uv_event",  0, {7'd0, update_valid}, 8'd1);
    @(negedge clk);
    post_spike = 1'b0; wload_data = 8'd17;
    @(posedge clk);
    #1;
    check("load_only_weight", 1, weight, 8'd17);
    check("load_only_uv",     1, {7'd0, update_valid}, 8'd0);
    @(negedge clk);
    wload_valid = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
